// File: rtl/sd_arb_pkg.sv
// Shared definitions for the sd_block_arbiter virtual-disk channel sharer:
// controller state encoding, buffer data width helper and watchdog default.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_DONE
  } arb_state_t;

  localparam int TO_W_DEFAULT = 24;

  // Top bit index of the sector buffer data bus for a given hps_io WIDE setting.
  function automatic int dw_of(input int wide);
    return (wide != 0) ? 15 : 7;
  endfunction

endpackage

// File: rtl/sd_block_arbiter_rr_pick.sv
// Round-robin priority picker: first requester after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // NREQ need not be a power of two, so wrap explicitly instead of overflowing.
    for (int k = 1; k <= NREQ; k++) begin
      if (int'(last) + k >= NREQ) cand = IW'(int'(last) + k - NREQ);
      else                        cand = IW'(int'(last) + k);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one hps_io virtual-disk block channel between NREQ clients, one sector
// request at a time, with round-robin arbitration and a request watchdog.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int WIDE = 0,
  parameter  int TO_W = TO_W_DEFAULT,
  localparam int DW   = dw_of(WIDE),
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,

  input  logic [32*NREQ-1:0]     cl_lba,
  input  logic [NREQ-1:0]        cl_rd,
  input  logic [NREQ-1:0]        cl_wr,
  output logic [NREQ-1:0]        cl_ack,
  output logic [NREQ-1:0]        cl_done,
  output logic [NREQ-1:0]        cl_err,
  output logic [NREQ-1:0]        cl_buff_wr,
  input  logic [(DW+1)*NREQ-1:0] cl_buff_din,

  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [DW:0]            sd_buff_din
);

  arb_state_t       state;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    rr_last;
  logic [TO_W-1:0]  wd;

  logic [NREQ-1:0]  pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (cl_rd | cl_wr),
    .last  (rr_last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the values from before the clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_last <= IW'(NREQ - 1);
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      wd      <= '0;
      cl_done <= '0;
      cl_err  <= '0;
    end else begin
      cl_done <= '0;
      cl_err  <= '0;
      case (state)
        ST_IDLE: begin
          // A leftover ack from a previous owner must drain before a new command.
          if (!sd_ack && pick_any) begin
            grant   <= pick_grant;
            rr_last <= pick_idx;
            sd_lba  <= cl_lba[32*pick_idx +: 32];
            sd_rd   <= cl_rd[pick_idx] & ~cl_wr[pick_idx];
            sd_wr   <= cl_wr[pick_idx];
            wd      <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end else if (&wd) begin
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
            cl_err <= grant;
            grant  <= '0;
            state  <= ST_IDLE;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        ST_XFER: begin
          if (!sd_ack) state <= ST_DONE;
        end
        ST_DONE: begin
          cl_done <= grant;
          grant   <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Zero-latency routing keeps buffer strobes aligned with hps_io's sd_buff_addr.
  assign cl_ack     = grant & {NREQ{sd_ack}};
  assign cl_buff_wr = grant & {NREQ{sd_buff_wr}};

  always_comb begin
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sd_buff_din = cl_buff_din[i*(DW+1) +: DW+1];
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter: directed client/HPS sequences push
// expected commands and completions; a negedge monitor pops and compares.
module tb_sd_block_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 7;
  localparam int TO_W = 4;

  logic                   clk_sys = 1'b0;
  logic                   reset_n;
  logic [32*NREQ-1:0]     cl_lba;
  logic [NREQ-1:0]        cl_rd, cl_wr;
  logic [NREQ-1:0]        cl_ack, cl_done, cl_err, cl_buff_wr;
  logic [(DW+1)*NREQ-1:0] cl_buff_din;
  logic [31:0]            sd_lba;
  logic                   sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [DW:0]            sd_buff_din;

  sd_block_arbiter #(.NREQ(NREQ), .WIDE(0), .TO_W(TO_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cl_lba      (cl_lba),
    .cl_rd       (cl_rd),
    .cl_wr       (cl_wr),
    .cl_ack      (cl_ack),
    .cl_done     (cl_done),
    .cl_err      (cl_err),
    .cl_buff_wr  (cl_buff_wr),
    .cl_buff_din (cl_buff_din),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {EV_CMD, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    logic [31:0]     lba;
    logic            rd;
    logic            wr;
    logic [NREQ-1:0] vec;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bw_cnt[NREQ];
  logic prev_cmd = 1'b0;

  logic [31:0] lba_tab [NREQ] = '{32'h0000_1234, 32'h00AB_CDEF, 32'h0222_0000};
  logic [7:0]  din_tab [NREQ] = '{8'h3C, 8'hA5, 8'h5A};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_cmd(input logic [31:0] lba, input logic rd, input logic wr);
    ev_t e;
    e.kind = EV_CMD; e.lba = lba; e.rd = rd; e.wr = wr; e.vec = '0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_end(input ev_kind_t k, input logic [NREQ-1:0] vec);
    ev_t e;
    e.kind = k; e.lba = '0; e.rd = 1'b0; e.wr = 1'b0; e.vec = vec;
    exp_q.push_back(e);
  endfunction

  task automatic expect_event(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d seen with nothing expected", k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      case (k)
        EV_CMD: begin
          check("cmd_lba", 64'(sd_lba), 64'(e.lba));
          check("cmd_rd",  64'(sd_rd),  64'(e.rd));
          check("cmd_wr",  64'(sd_wr),  64'(e.wr));
        end
        EV_DONE: check("done_vec", 64'(cl_done), 64'(e.vec));
        default: check("err_vec",  64'(cl_err),  64'(e.vec));
      endcase
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command or completion.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_cmd = 1'b0;
    end else begin
      if ((sd_rd | sd_wr) && !prev_cmd) expect_event(EV_CMD);
      if (|cl_done) expect_event(EV_DONE);
      if (|cl_err)  expect_event(EV_ERR);
      prev_cmd = sd_rd | sd_wr;
    end
    for (int i = 0; i < NREQ; i++) bw_cnt[i] += int'(cl_buff_wr[i]);
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({sd_rd, sd_wr, cl_ack, cl_done, cl_err, cl_buff_wr, sd_buff_din}), 64'd0);
    check({name, "_lba"}, 64'(sd_lba), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!(sd_rd | sd_wr) && n < 40);
    check({name, "_issued"}, 64'(sd_rd | sd_wr), 64'd1);
  endtask

  // HPS side: ack the pending command and strobe n buffer words to client c.
  task automatic hps_xfer(input int c, input int n);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << c;
    @(posedge clk_sys); #1;
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    cl_rd = cl_rd & ~oh; cl_wr = cl_wr & ~oh;
    @(negedge clk_sys);
    check("ack_route", 64'(cl_ack), 64'(oh));
    check("cmd_held_at_ack", 64'(sd_rd | sd_wr), 64'd1);
    check("buff_din_route", 64'(sd_buff_din), 64'(din_tab[c]));
    for (int k = 1; k < n; k++) begin
      @(posedge clk_sys); #1;
      if (k == 1) begin
        @(negedge clk_sys);
        check("cmd_clear_after_ack", 64'(sd_rd | sd_wr), 64'd0);
      end
    end
    @(posedge clk_sys); #1;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
  endtask

  initial begin
    int snap[NREQ];
    int stale_seen;

    reset_n = 1'b0; sd_ack = 1'b1; sd_buff_wr = 1'b1;
    cl_rd = 3'b001; cl_wr = 3'b000;
    cl_lba = {lba_tab[2], lba_tab[1], lba_tab[0]};
    cl_buff_din = {din_tab[2], din_tab[1], din_tab[0]};
    #12;
    check_zero("reset_state");
    sd_buff_wr = 1'b0;
    @(posedge clk_sys); #1 reset_n = 1'b1;

    // Stale ack: client 0 waits until sd_ack falls.
    stale_seen = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (sd_rd | sd_wr) stale_seen = 1;
    end
    check("stale_ack_hold", 64'(stale_seen), 64'd0);
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    @(posedge clk_sys); #1 sd_ack = 1'b0;
    @(negedge clk_sys); check("stale_lat_first", 64'(sd_rd), 64'd0);
    @(negedge clk_sys); check("stale_lat_second", 64'(sd_rd), 64'd1);
    hps_xfer(0, 2);
    settle(4);

    // Single read of a full 512-word sector.
    snap = bw_cnt;
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b001;
    @(negedge clk_sys); check("single_lat_first", 64'(sd_rd), 64'd0);
    @(negedge clk_sys); check("single_rd", 64'(sd_rd), 64'd1);
    check("single_lba", 64'(sd_lba), 64'h1234);
    hps_xfer(0, 512);
    settle(4);
    check("single_strobes_c0", 64'(bw_cnt[0] - snap[0]), 64'd512);
    check("single_strobes_c1", 64'(bw_cnt[1] - snap[1]), 64'd0);

    // Strobes with no grant are dropped.
    snap = bw_cnt;
    @(posedge clk_sys); #1 sd_buff_wr = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    check("dropped_strobes", 64'((bw_cnt[0] - snap[0]) + (bw_cnt[1] - snap[1]) + (bw_cnt[2] - snap[2])), 64'd0);

    // Contention after reset: 0 first, then 1 (write), then 0 again.
    do_reset();
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    push_cmd(lba_tab[1], 1'b0, 1'b1); push_end(EV_DONE, 3'b010);
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    @(posedge clk_sys); #1;
    cl_rd = cl_rd | 3'b001; cl_wr = cl_wr | 3'b010;
    wait_cmd("cont_c0");
    hps_xfer(0, 4);
    cl_rd = cl_rd | 3'b001;
    wait_cmd("cont_c1");
    snap = bw_cnt;
    hps_xfer(1, 4);
    check("cont_strobes_c1", 64'(bw_cnt[1] - snap[1]), 64'd4);
    check("cont_strobes_c0", 64'(bw_cnt[0] - snap[0]), 64'd0);
    wait_cmd("cont_c0_again");
    hps_xfer(0, 2);
    settle(4);

    // Watchdog: client 1 never acked, error 16 cycles after ISSUE entry.
    push_cmd(lba_tab[1], 1'b1, 1'b0); push_end(EV_ERR, 3'b010);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b010;
    wait_cmd("wd_c1");
    for (int k = 1; k <= 15; k++) @(negedge clk_sys);
    check("wd_no_err_early", 64'(cl_err), 64'd0);
    check("wd_rd_held", 64'(sd_rd), 64'd1);
    @(negedge clk_sys);
    check("wd_err_pulse", 64'(cl_err), 64'(3'b010));
    check("wd_rd_cleared", 64'(sd_rd), 64'd0);
    cl_rd = cl_rd & ~3'b010;
    @(negedge clk_sys);
    check("wd_err_one_cycle", 64'(cl_err), 64'd0);
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b001;
    wait_cmd("wd_after");
    hps_xfer(0, 2);
    settle(4);

    // rd and wr together: write wins.
    push_cmd(lba_tab[0], 1'b0, 1'b1); push_end(EV_DONE, 3'b001);
    @(posedge clk_sys); #1;
    cl_rd = cl_rd | 3'b001; cl_wr = cl_wr | 3'b001;
    wait_cmd("rdwr");
    hps_xfer(0, 2);
    settle(4);

    // Wrap: after client 2 is served, requests on 2 and 0 grant 0 first.
    push_cmd(lba_tab[2], 1'b1, 1'b0); push_end(EV_DONE, 3'b100);
    push_cmd(lba_tab[0], 1'b1, 1'b0); push_end(EV_DONE, 3'b001);
    push_cmd(lba_tab[2], 1'b1, 1'b0); push_end(EV_DONE, 3'b100);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b100;
    wait_cmd("wrap_c2");
    hps_xfer(2, 2);
    cl_rd = cl_rd | 3'b101;
    wait_cmd("wrap_c0");
    hps_xfer(0, 2);
    wait_cmd("wrap_c2_again");
    hps_xfer(2, 2);
    settle(4);

    // Reset during XFER clears everything immediately.
    push_cmd(lba_tab[0], 1'b1, 1'b0);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b001;
    wait_cmd("midx_c0");
    @(posedge clk_sys); #1;
    sd_ack = 1'b1; sd_buff_wr = 1'b1; cl_rd = cl_rd & ~3'b001;
    @(posedge clk_sys); #1;
    check("midx_ack_route", 64'(cl_ack), 64'(3'b001));
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid_xfer");
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    push_cmd(lba_tab[1], 1'b1, 1'b0); push_end(EV_DONE, 3'b010);
    @(posedge clk_sys); #1 cl_rd = cl_rd | 3'b010;
    wait_cmd("post_reset_c1");
    hps_xfer(1, 2);
    settle(6);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares one virtual-disk block channel of hps_io (sd_lba/sd_rd/sd_wr/sd_ack, sd_buff_*) between NREQ core-side clients, e.g. the CD-ROM sector reader and the save-RAM backup.
- Arbitrates round-robin, issues one sector request at a time to the HPS, and routes ack, buffer strobe and buffer read data to the granted client only.
- Adds a request watchdog so that an unanswered request cannot hang the channel.

Parameters:
- NREQ, 2, number of clients (2..4).
- WIDE, 0, 1 = 16-bit buffer data; matches the hps_io WIDE setting.
- TO_W, 24, watchdog width; timeout fires when the counter reaches 2^TO_W-1 cycles.
- DW, derived, WIDE ? 15 : 7.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cl_lba  in  32*NREQ  per-client sector LBA; client i uses bits [32i+31:32i].
- cl_rd  in  NREQ  per-client read request; level, held until its cl_ack rises.
- cl_wr  in  NREQ  per-client write request; level, held until its cl_ack rises.
- cl_ack  out  NREQ  sd_ack routed to the granted client.
- cl_done  out  NREQ  1-cycle pulse when the transfer completes.
- cl_err  out  NREQ  1-cycle pulse on watchdog timeout.
- cl_buff_wr  out  NREQ  sd_buff_wr routed to the granted client.
- cl_buff_din  in  (DW+1)*NREQ  per-client write-sector data.
- sd_lba  out  32  to hps_io.
- sd_rd  out  1  to hps_io.
- sd_wr  out  1  to hps_io.
- sd_ack  in  1  from hps_io.
- sd_buff_wr  in  1  from hps_io.
- sd_buff_din  out  DW+1  to hps_io; data of the granted client.
- (sd_buff_addr and sd_buff_dout are broadcast from hps_io to all clients directly and do not pass through this block.)

Behaviour:
- Reset (async, reset_n=0): state IDLE; grant none (one-hot 0); sd_rd=sd_wr=0; sd_lba=0; all cl_* outputs 0; watchdog 0; rr_last=NREQ-1, so client 0 has priority first.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - If sd_ack=1 (stale ack), stay in IDLE.
  - Otherwise, if any client has rd or wr set, pick the first requester searching from rr_last+1 and wrapping modulo NREQ.
  - Next edge: register the one-hot grant, set rr_last=g, sd_lba<=cl_lba[g], sd_rd<=cl_rd[g]&~cl_wr[g], sd_wr<=cl_wr[g], watchdog<=0; go to ISSUE.
  - If a client asserts rd and wr together, write wins.
  - sd_rd/sd_wr are registered: they appear 1 cycle after the request is sampled.
- ISSUE:
  - sd_lba is held constant. The watchdog increments every cycle.
  - On sd_ack=1: clear sd_rd/sd_wr on the next edge and go to XFER.
  - On watchdog=all-ones with sd_ack=0: clear sd_rd/sd_wr, pulse cl_err[g] for 1 cycle, clear grant, go to IDLE.
  - If the client drops its request while in ISSUE, ignore it: the command is already visible to the HPS.
- XFER: wait for sd_ack=0, then go to DONE.
- DONE: pulse cl_done[g] for 1 cycle, clear grant, go to IDLE. IDLE can issue a new grant on the following cycle.
- Routing (combinational, zero latency, required for buffer address timing):
  - cl_ack[i] = sd_ack & grant[i].
  - cl_buff_wr[i] = sd_buff_wr & grant[i].
  - sd_buff_din = cl_buff_din of the granted client, 0 if none.
- A client whose request is still high after DONE is treated as a new request; round-robin places it behind the other waiting clients.
- sd_buff_wr arriving while grant=none is dropped.
- Width rules:
  - Grant index is clog2(NREQ) bits; round-robin wrap is modulo NREQ, not a power of 2.
  - Watchdog saturates at its terminal count and never wraps.

Decomposition:
- Shared package sd_arb_pkg: state enum (IDLE/ISSUE/XFER/DONE), the DW function of WIDE, the default TO_W.
- One natural sub-module rr_pick: NREQ-wide round-robin priority picker; inputs req and last, output one-hot grant plus index.

Test Plan:
- Single read: cl_rd[0]=1 with lba=0x00001234 -> sd_rd=1 and sd_lba=0x1234 two cycles later. sd_ack high for 512 cycles with 512 sd_buff_wr strobes -> cl_buff_wr[0] sees 512 pulses, cl_buff_wr[1] sees 0, sd_rd clears 1 cycle after ack rises, cl_done[0] pulses once after ack falls.
- Contention: cl_rd[0] and cl_wr[1] asserted in the same cycle after reset -> client 0 served first. Client 1 served next with sd_wr=1 and sd_buff_din equal to cl_buff_din[1] (e.g. 0xA5). Client 0 re-requesting immediately is served after client 1.
- Watchdog: TO_W=4, cl_rd[1]=1, sd_ack held low -> cl_err[1] pulses at cycle 16 after ISSUE entry, sd_rd returns to 0, state returns to IDLE, and the next request is granted normally.
- Stale ack: sd_ack=1 at reset release with cl_rd[0]=1 -> no sd_rd until sd_ack=0; sd_rd asserted 2 cycles after the ack falls.
- Reset mid-XFER: drop reset_n during XFER -> all outputs 0 immediately. After release, cl_rd[1] alone is granted with the correct lba.
- rd+wr together on client 0 with NREQ=3 -> sd_wr=1, sd_rd=0. Round-robin wrap check: with rr_last=2 and requests on clients 2 and 0, client 0 is granted.
